// File: rtl/ysyx_24080014_lsu_pkg.sv
// ysyx_24080014_pkg: shared LSU types, funct3 encodings and access-legality helper
//   state_t     : LSU FSM states IDLE/REQ/RESP/DONE
//   F3_*        : RV32 load/store funct3 encodings
//   bad_access  : 1 when funct3 is illegal for the op or the address is misaligned
package ysyx_24080014_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    function automatic logic bad_access(input logic ld, input logic [2:0] f3, input logic [1:0] off);
        logic legal;
        legal = ld ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU) : (f3 <= F3_W);
        return !legal || (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction
endpackage

// File: rtl/ysyx_24080014_lsu_if.sv
// ysyx_24080014_lsu_if: EXU-side and data-memory-side signals of the LSU
//   EXU     : valid/load/store/funct3/addr/wdata in, busy/mem_ready/rd_data/err out
//   memory  : req_valid/req_wen/req_addr/req_wdata/req_wmask out, req_ready in,
//             resp_valid/resp_rdata in, resp_ready out
//   slave   : the LSU's view; master : the environment (EXU + memory) view
interface ysyx_24080014_lsu_if;
    logic        valid;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        mem_ready;
    logic [31:0] rd_data;
    logic        err;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    modport slave (
        input  valid, load, store, funct3, addr, wdata, req_ready, resp_valid, resp_rdata,
        output busy, mem_ready, rd_data, err, req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready
    );
    modport master (
        output valid, load, store, funct3, addr, wdata, req_ready, resp_valid, resp_rdata,
        input  busy, mem_ready, rd_data, err, req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready
    );
endinterface

// File: rtl/ysyx_24080014_lsu_align.sv
// ysyx_24080014_lsu_align: byte-lane steering for stores and extraction/extension for loads
//   i_funct3 : access size/sign        i_off   : addr[1:0]
//   i_wdata  : raw store data          o_wmask : byte strobes, o_wdata : lane-replicated data
//   i_rdata  : raw read word           o_rdata : shifted and sign/zero-extended load result
module ysyx_24080014_lsu_align
    import ysyx_24080014_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_sh;
    always_comb begin
        o_wmask = i_funct3[1:0] == F3_B[1:0] ? 4'b0001 << i_off :
                  i_funct3[1:0] == F3_H[1:0] ? 4'b0011 << {i_off[1], 1'b0} : 4'b1111;
        o_wdata = i_funct3[1:0] == F3_B[1:0] ? {4{i_wdata[7:0]}} :
                  i_funct3[1:0] == F3_H[1:0] ? {2{i_wdata[15:0]}} : i_wdata;
        w_sh    = i_rdata >> {i_off, 3'b000};
        o_rdata = i_funct3 == F3_B  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                  i_funct3 == F3_H  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                  i_funct3 == F3_BU ? {24'b0, w_sh[7:0]} :
                  i_funct3 == F3_HU ? {16'b0, w_sh[15:0]} : w_sh;
    end
endmodule

// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu: load/store unit between EXU and the data-memory port
//   clk, rst : clock, asynchronous active-high reset
//   io       : EXU handshake (valid/load/store/funct3/addr/wdata -> busy/mem_ready/rd_data/err)
//              and memory request/response channels (req_* / resp_*)
//   TIMEOUT_CYC : RESP cycles before abort with error (0 = never); CNT_W : counter width
module ysyx_24080014_lsu
    import ysyx_24080014_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input logic clk,
    input logic rst,
    ysyx_24080014_lsu_if.slave io
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [2:0]  r_f3;
    logic        r_load, r_err;
    logic [CNT_W-1:0] r_cnt;
    logic        w_start, w_bad, w_tmo;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata, w_ld;
    ysyx_24080014_lsu_align u_align (
        .i_funct3(r_f3),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (io.resp_rdata),
        .o_wmask (w_wmask),
        .o_wdata (w_wdata),
        .o_rdata (w_ld)
    );
    assign w_start = r_state == IDLE && io.valid && (io.load || io.store);
    assign w_bad   = (io.load && io.store) || bad_access(io.load, io.funct3, io.addr[1:0]);
    // timeout fires on the last allowed RESP cycle so DONE follows exactly TIMEOUT_CYC RESP cycles
    assign w_tmo   = TIMEOUT_CYC != 0 && r_cnt == TMO_LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_bad ? DONE : REQ;
            REQ:     if (io.req_ready) w_next = RESP;
            RESP:    if (io.resp_valid || w_tmo) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_load  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rd    <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= io.addr;
                r_wdata <= io.wdata;
                r_f3    <= io.funct3;
                r_load  <= io.load;
                r_err   <= w_bad;
                if (w_bad) r_rd <= '0;
            end
            if (r_state == REQ && io.req_ready) r_cnt <= '0;
            if (r_state == RESP) begin
                if (io.resp_valid) begin
                    if (r_load) r_rd <= w_ld;
                end else if (w_tmo) begin
                    r_err <= 1'b1;
                    r_rd  <= '0;
                end else r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    // request fields are zeroed outside REQ so idle/reset outputs read as 0
    always_comb begin
        io.busy       = r_state != IDLE;
        io.mem_ready  = r_state == DONE;
        io.err        = r_state == DONE && r_err;
        io.rd_data    = r_rd;
        io.req_valid  = r_state == REQ;
        io.req_wen    = r_state == REQ && !r_load;
        io.req_addr   = r_state == REQ ? {r_addr[31:2], 2'b00} : 32'b0;
        io.req_wdata  = r_state == REQ && !r_load ? w_wdata : 32'b0;
        io.req_wmask  = r_state == REQ && !r_load ? w_wmask : 4'b0;
        io.resp_ready = r_state == RESP;
    end
endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// tb_ysyx_24080014_lsu: directed self-checking bench for the LSU
module tb_ysyx_24080014_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    ysyx_24080014_lsu_if bus();
    ysyx_24080014_lsu #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // presents one op for a single cycle (T); returns at the negedge of T+1
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.load = ld;
        bus.store = st;
        bus.funct3 = f3;
        bus.addr = a;
        bus.wdata = wd;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.load = 1'b0;
        bus.store = 1'b0;
    endtask
    initial begin
        bus.valid = 0; bus.load = 0; bus.store = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
        bus.req_ready = 0; bus.resp_valid = 0; bus.resp_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {bus.busy, bus.mem_ready, bus.err, bus.req_valid, bus.req_wen, bus.resp_ready, bus.req_wmask}, 0);
        chk("rst_rd", bus.rd_data, 0);
        chk("rst_raddr", bus.req_addr, 0);
        chk("rst_rwdata", bus.req_wdata, 0);
        rst = 1'b0;
        // LB zero-wait
        bus.req_ready = 1; bus.resp_valid = 1; bus.resp_rdata = 32'h80FF1234;
        issue(1, 0, 3'b000, 32'h80000003, 0);
        chk("lb_reqv", bus.req_valid, 1);
        chk("lb_wen", bus.req_wen, 0);
        chk("lb_addr", bus.req_addr, 32'h80000000);
        chk("lb_wmask", bus.req_wmask, 0);
        chk("lb_busy", bus.busy, 1);
        chk("lb_mr_t1", bus.mem_ready, 0);
        @(negedge clk);
        chk("lb_rresp", bus.resp_ready, 1);
        chk("lb_mr_t2", bus.mem_ready, 0);
        @(negedge clk);
        chk("lb_mr_t3", bus.mem_ready, 1);
        chk("lb_err", bus.err, 0);
        chk("lb_rd", bus.rd_data, 32'hFFFFFF80);
        @(negedge clk);
        chk("lb_mr_t4", bus.mem_ready, 0);
        chk("lb_idle", bus.busy, 0);
        // LHU / LH
        bus.resp_rdata = 32'hBEEF0000;
        issue(1, 0, 3'b101, 32'h80000102, 0);
        repeat (2) @(negedge clk);
        chk("lhu_mr", bus.mem_ready, 1);
        chk("lhu_rd", bus.rd_data, 32'h0000BEEF);
        issue(1, 0, 3'b001, 32'h80000102, 0);
        repeat (2) @(negedge clk);
        chk("lh_mr", bus.mem_ready, 1);
        chk("lh_rd", bus.rd_data, 32'hFFFFBEEF);
        // SB
        issue(0, 1, 3'b000, 32'h80000001, 32'h123456AB);
        chk("sb_wen", bus.req_wen, 1);
        chk("sb_addr", bus.req_addr, 32'h80000000);
        chk("sb_wmask", bus.req_wmask, 4'b0010);
        chk("sb_wdata", bus.req_wdata, 32'hABABABAB);
        repeat (2) @(negedge clk);
        chk("sb_mr", bus.mem_ready, 1);
        chk("sb_rd", bus.rd_data, 32'hFFFFBEEF);
        @(negedge clk);
        chk("sb_mr_off", bus.mem_ready, 0);
        // SH upper half
        issue(0, 1, 3'b001, 32'h10000002, 32'h0000CAFE);
        chk("sh_wmask", bus.req_wmask, 4'b1100);
        chk("sh_wdata", bus.req_wdata, 32'hCAFECAFE);
        repeat (3) @(negedge clk);
        // LBU offset 1
        bus.resp_rdata = 32'h80FF1234;
        issue(1, 0, 3'b100, 32'h80000001, 0);
        repeat (2) @(negedge clk);
        chk("lbu_rd", bus.rd_data, 32'h00000012);
        // misaligned LW
        issue(1, 0, 3'b010, 32'h80000002, 0);
        chk("mis_reqv", bus.req_valid, 0);
        chk("mis_mr", bus.mem_ready, 1);
        chk("mis_err", bus.err, 1);
        chk("mis_rd", bus.rd_data, 0);
        @(negedge clk);
        chk("mis_off", {bus.mem_ready, bus.err, bus.busy, bus.req_valid}, 0);
        // illegal store funct3 and load+store together
        issue(0, 1, 3'b011, 32'h80000000, 0);
        chk("ill_st", {bus.mem_ready, bus.err, bus.req_valid}, 3'b110);
        issue(1, 1, 3'b010, 32'h80000000, 0);
        chk("ldst", {bus.mem_ready, bus.err, bus.req_valid}, 3'b110);
        @(negedge clk);
        // restore a nonzero rd_data, then request stall and response timeout
        bus.resp_rdata = 32'h55667788;
        issue(1, 0, 3'b010, 32'h80000004, 0);
        repeat (3) @(negedge clk);
        chk("lw_rd", bus.rd_data, 32'h55667788);
        bus.req_ready = 0; bus.resp_valid = 0;
        issue(1, 0, 3'b010, 32'h80000010, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", {bus.req_valid, bus.req_wen, bus.req_wmask}, 6'b100000);
            chk("stall_addr", bus.req_addr, 32'h80000010);
            @(negedge clk);
        end
        bus.req_ready = 1;
        chk("stall_req4", bus.req_valid, 1);
        chk("stall_addr4", bus.req_addr, 32'h80000010);
        @(negedge clk);
        bus.req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_wait", {bus.resp_ready, bus.mem_ready, bus.err}, 3'b100);
            @(negedge clk);
        end
        chk("tmo_done", {bus.mem_ready, bus.err}, 2'b11);
        chk("tmo_rd", bus.rd_data, 0);
        @(negedge clk);
        chk("tmo_idle", bus.busy, 0);
        // reset during RESP
        bus.resp_rdata = 32'h11223344; bus.req_ready = 1;
        issue(1, 0, 3'b010, 32'h80000020, 0);
        @(negedge clk);
        chk("rr_inresp", bus.resp_ready, 1);
        rst = 1'b1;
        #1;
        chk("rr_async", {bus.busy, bus.resp_ready, bus.req_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.resp_valid = 1; bus.resp_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.resp_valid = 0;
        chk("rr_ctl", {bus.busy, bus.mem_ready, bus.err, bus.req_valid, bus.req_wen, bus.resp_ready, bus.req_wmask}, 0);
        chk("rr_rd", bus.rd_data, 0);
        @(negedge clk);
        chk("rr_mr", bus.mem_ready, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_24080014_lsu.md
Name: ysyx_24080014_lsu

Overview:
- Load/store unit: the memory-side producer of the `mem_ready`/`rd_data` handshake that the GPR file consumes for loads.
- Accepts one load or store from execute and issues it to data memory over a valid/ready request plus response channel.
- On completion, pulses `mem_ready` for one cycle; for loads, `rd_data` carries the byte-lane-extracted, sign- or zero-extended result.
- Sits between EXU and the data-memory port; the register file writes back on the `mem_ready` pulse.

Parameters:
- TIMEOUT_CYC, 255: maximum wait cycles in RESP before the operation is aborted with an error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid  in  1  execute-stage instruction valid
- load  in  1  instruction is a load
- store  in  1  instruction is a store
- funct3  in  3  RV32 funct3 (access size and sign)
- addr  in  32  effective byte address
- wdata  in  32  store data (rs2)
- busy  out  1  operation in flight; EXU holds its inputs
- mem_ready  out  1  one-cycle completion pulse
- rd_data  out  32  extended load result
- err  out  1  one-cycle pulse coincident with mem_ready on misalign, illegal op or timeout
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_wen  out  1  1 = write
- req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- req_wdata  out  32  lane-replicated store data
- req_wmask  out  4  byte strobes
- resp_valid  in  1  response valid
- resp_ready  out  1  high only in state RESP
- resp_rdata  in  32  read word

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; captured registers 0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If valid && (load ^ store): capture addr, funct3, wdata and the load flag.
  - If the access is misaligned (half-word with addr[0]=1, or word with addr[1:0]≠0) or funct3 is illegal (load 011/110/111; store funct3>010): go to DONE with an error flag set, issue no request.
  - Otherwise go to REQ.
  - valid && load && store: error, go to DONE.
  - Any other input combination: stay in IDLE.
- REQ:
  - req_valid=1 with req_wen/addr/wdata/wmask held stable until req_ready.
  - req_valid && req_ready → RESP, counter cleared.
- RESP:
  - resp_ready=1.
  - On resp_valid: register the load result into rd_data (stores leave rd_data unchanged) → DONE.
  - Otherwise the counter increments; when the counter reaches TIMEOUT_CYC (if nonzero) → DONE with error.
- DONE:
  - mem_ready=1 for exactly one cycle; err=1 in this cycle if the error flag is set.
  - Then → IDLE.
- busy = (state != IDLE). Inputs are ignored while busy.
- Latency: capture in cycle T; req_valid in T+1; with zero-wait memory (req_ready and resp_valid each asserted on first opportunity), response at T+2 and mem_ready at T+3. Each extra wait cycle adds 1.
- Store encoding:
  - SB: wmask = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111; wdata unchanged.
  - Loads: wmask = 0, req_wen = 0.
- Load decode:
  - shifted = resp_rdata >> (8*addr[1:0]).
  - LB (000) sign-extends shifted[7:0]; LH (001) sign-extends [15:0]; LW (010) takes all 32 bits.
  - LBU (100) zero-extends [7:0]; LHU (101) zero-extends [15:0].
- rd_data holds its value until the next load completes. On an error it is forced to 0.
- resp_valid while not in RESP (stale or post-reset) is ignored.
- Reset mid-operation: returns to IDLE immediately and deasserts req_valid. No mem_ready is produced for the aborted operation.

Decomposition:
- Shared package ysyx_24080014_pkg holds:
  - state enum IDLE/REQ/RESP/DONE;
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One natural sub-module, ysyx_24080014_lsu_align (combinational):
  - store side: funct3 + addr[1:0] + wdata → wmask/wdata;
  - load side: funct3 + addr[1:0] + rdata → extended result.
- The FSM and timeout counter stay in the top module.

Test Plan:
- LB, addr 0x80000003, zero-wait memory, resp_rdata 0x80FF1234 → mem_ready at T+3, rd_data 0xFFFFFF80, err 0.
- LHU, addr 0x80000102, resp_rdata 0xBEEF0000 → rd_data 0x0000BEEF. The same operation as LH → 0xFFFFBEEF.
- SB, addr 0x80000001, wdata 0x123456AB → req_wen 1, req_addr 0x80000000, req_wmask 4'b0010, req_wdata 0xABABABAB. mem_ready pulses once; rd_data unchanged.
- LW, addr 0x80000002 → no req_valid ever; err and mem_ready high together at T+1 for one cycle; rd_data 0.
- req_ready low for 3 cycles, then high → req_* stable for all 4 cycles of req_valid. Then with TIMEOUT_CYC=4 and resp_valid never asserted → err and mem_ready after 4 RESP cycles, then busy returns to 0.
- Assert rst during RESP, then drive resp_valid 2 cycles after reset release → no mem_ready, state IDLE, all outputs 0.
